cla16_share_arb: RTL

- Round-robin arbiter and sequencer that shares one 16-bit carry-look-ahead adder among NUM_REQ requesters.
- Each requester presents operands a, b and cin with a valid/ready handshake. The block grants one requester, registers its operands, and drives the shared cla16 instance.
- The registered sum and carry-out are returned on a single tagged response channel.
- It sits between client units (address generators, accumulators) and the single adder instance.

---
 rtl/cla16_share_arb.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cla16_share_arb.sv
// cla16_share_arb: round-robin arbiter and 3-state sequencer sharing a single
// 16-bit carry-look-ahead adder among NUM_REQ valid/ready requesters.
// The result comes back on one tagged response channel.
// Optional statistics counters are built when CLA16_SHARE_ARB_STATS_EN is defined.

// Two-level 16-bit carry-look-ahead adder: 4-bit groups with a group-level look-ahead.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [15:0] c_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  gc_s;

    // Bit generate/propagate, group look-ahead, then bit carries inside each group.
    always_comb begin
        g_s = a & b;
        p_s = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            gp_s[k] = &p_s[4*k +: 4];
        end
        gc_s[0] = cin;
        gc_s[1] = gg_s[0] | (gp_s[0] & cin);
        gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
        gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
        gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = gc_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
        end
        sum  = p_s ^ c_s;
        cout = gc_s[4];
    end
endmodule

module cla16_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_sum,
    output logic                    rsp_cout
`ifdef CLA16_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]             op_count,
    output logic [15:0]             cout_count
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   grant_s;
    logic [ID_W-1:0]   id_r;
    logic              found_s;
    logic              accept_s;
    logic              rsp_fire_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [15:0]       sel_a_s;
    logic [15:0]       sel_b_s;
    logic              sel_cin_s;
    logic [15:0]       op_a_r;
    logic [15:0]       op_b_r;
    logic              op_cin_r;
    logic [15:0]       sum_s;
    logic              cout_s;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [15:0]       rsp_sum_r;
    logic              rsp_cout_r;

    // (base + off) mod NUM_REQ; base is always below NUM_REQ and off never exceeds NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return ID_W'(s);
    endfunction

    // Round-robin search starting at rr_ptr; the descending loop lets the nearest valid index win.
    always_comb begin
        found_s = 1'b0;
        grant_s = {ID_W{1'b0}};
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_valid[wrap_add(rr_ptr_r, off)]) begin
                found_s = 1'b1;
                grant_s = wrap_add(rr_ptr_r, off);
            end else begin
                found_s = found_s;
                grant_s = grant_s;
            end
        end
    end

    assign accept_s   = (state_r == ST_IDLE) && found_s;
    assign rsp_fire_s = rsp_valid_r && rsp_ready;

    // One-hot ready for the granted requester; forced low while reset is asserted.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        if (accept_s && rst_n) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Operand mux selecting the granted requester's a/b/cin slice.
    always_comb begin
        sel_a_s   = 16'h0000;
        sel_b_s   = 16'h0000;
        sel_cin_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s == ID_W'(i)) begin
                sel_a_s   = req_a[16*i +: 16];
                sel_b_s   = req_b[16*i +: 16];
                sel_cin_s = req_cin[i];
            end else begin
                sel_a_s   = sel_a_s;
                sel_b_s   = sel_b_s;
                sel_cin_s = sel_cin_s;
            end
        end
    end

    // Next-state logic: IDLE waits for a grant, EXEC lasts one cycle, RESP waits for the consumer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // The single shared adder only ever sees the registered operands.
    cla16 u_cla16 (
        .a    (op_a_r),
        .b    (op_b_r),
        .cin  (op_cin_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Operand capture, rr pointer advance and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= {ID_W{1'b0}};
            id_r        <= {ID_W{1'b0}};
            op_a_r      <= 16'h0000;
            op_b_r      <= 16'h0000;
            op_cin_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_sum_r   <= 16'h0000;
            rsp_cout_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                op_a_r   <= sel_a_s;
                op_b_r   <= sel_b_s;
                op_cin_r <= sel_cin_s;
                id_r     <= grant_s;
                rr_ptr_r <= wrap_add(grant_s, 1);
            end
            if (state_r == ST_EXEC) begin
                rsp_sum_r   <= sum_s;
                rsp_cout_r  <= cout_s;
                rsp_id_r    <= id_r;
                rsp_valid_r <= 1'b1;
            end else if (rsp_fire_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;

`ifdef CLA16_SHARE_ARB_STATS_EN
    logic [15:0] op_count_r;
    logic [15:0] cout_count_r;

    // Wrapping counters of completed responses and of those that carried out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r   <= 16'h0000;
            cout_count_r <= 16'h0000;
        end else if (rsp_fire_s) begin
            op_count_r <= op_count_r + 16'h0001;
            if (rsp_cout_r) begin
                cout_count_r <= cout_count_r + 16'h0001;
            end
        end
    end

    assign op_count   = op_count_r;
    assign cout_count = cout_count_r;
`endif
endmodule
